// File: rtl/io_input_ctrl.sv
// Input-port sequencer: 2-flop sync, per-port debounce FSM, committed registers, clear-on-read change status.
// Optional rise-edge capture registers are enabled with `define IO_INPUT_EDGE_EN.
module io_input_ctrl #(
    parameter int WIDTH      = 5,
    parameter int DEB_CYCLES = 4
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] io_read_data,
    output logic [31:0] in_reg0,
    output logic [31:0] in_reg1,
    output logic        chg_irq
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    logic [WIDTH-1:0] pin       [2];
    logic [WIDTH-1:0] sync1     [2];
    logic [WIDTH-1:0] sync2     [2];
    logic [WIDTH-1:0] cand      [2];
    logic [WIDTH-1:0] committed [2];
    logic [CW-1:0]    cnt       [2];
    state_t           state     [2];
    logic             chg_flag  [2];

    logic [5:0] word;
    logic       rd_status;
    logic       unused_bits;

    assign pin[0]      = in_port0[WIDTH-1:0];
    assign pin[1]      = in_port1[WIDTH-1:0];
    assign word        = addr[7:2];
    assign rd_status   = rd_en && (word == 6'd2);
    assign unused_bits = ^{in_port0, in_port1, addr};

`ifdef IO_INPUT_EDGE_EN
    logic [WIDTH-1:0] rise [2];
    logic [1:0]       rise_clr;
    assign rise_clr = {rd_en && (word == 6'd4), rd_en && (word == 6'd3)};
`endif

    for (genvar p = 0; p < 2; p++) begin : g_port
        always_ff @(posedge io_clk or negedge resetn) begin
            if (!resetn) begin
                sync1[p]     <= '0;
                sync2[p]     <= '0;
                cand[p]      <= '0;
                committed[p] <= '0;
                cnt[p]       <= '0;
                state[p]     <= IDLE;
                chg_flag[p]  <= 1'b0;
`ifdef IO_INPUT_EDGE_EN
                rise[p]      <= '0;
`endif
            end else begin
                sync1[p] <= pin[p];
                sync2[p] <= sync1[p];
                // Clears first so a commit on the same edge overrides them.
                if (rd_status) chg_flag[p] <= 1'b0;
`ifdef IO_INPUT_EDGE_EN
                if (rise_clr[p]) rise[p] <= '0;
`endif
                case (state[p])
                    IDLE: begin
                        if (sync2[p] != committed[p]) begin
                            cand[p]  <= sync2[p];
                            cnt[p]   <= '0;
                            state[p] <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (sync2[p] == committed[p]) begin
                            state[p] <= IDLE;
                        end else if (sync2[p] != cand[p]) begin
                            cand[p] <= sync2[p];
                            cnt[p]  <= '0;
                        end else if (cnt[p] == CW'(DEB_CYCLES - 1)) begin
                            committed[p] <= cand[p];
                            chg_flag[p]  <= 1'b1;
`ifdef IO_INPUT_EDGE_EN
                            rise[p]      <= (rise_clr[p] ? '0 : rise[p]) | (cand[p] & ~committed[p]);
`endif
                            state[p]     <= IDLE;
                        end else begin
                            cnt[p] <= cnt[p] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign in_reg0 = 32'(committed[0]);
    assign in_reg1 = 32'(committed[1]);

`ifdef IO_INPUT_EDGE_EN
    assign chg_irq = chg_flag[0] | chg_flag[1] | (|rise[0]) | (|rise[1]);
`else
    assign chg_irq = chg_flag[0] | chg_flag[1];
`endif

    always_comb begin
        io_read_data = '0;
        case (word)
            6'd0: io_read_data = in_reg0;
            6'd1: io_read_data = in_reg1;
            6'd2: io_read_data = {30'b0, chg_flag[1], chg_flag[0]};
`ifdef IO_INPUT_EDGE_EN
            6'd3: io_read_data = 32'(rise[0]);
            6'd4: io_read_data = 32'(rise[1]);
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: expected commits are queued at stimulus time and
// compared (value and edge number) when the committed register changes.
module tb_io_input_ctrl;
    localparam int W = 5;
    localparam int D = 4;
    localparam logic [31:0] MASK = 32'((64'd1 << W) - 64'd1);
`ifdef IO_INPUT_EDGE_EN
    localparam logic [31:0] RISE_EXP = 32'h12;
`else
    localparam logic [31:0] RISE_EXP = 32'h0;
`endif

    logic        io_clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] in_port0 = '0;
    logic [31:0] in_port1 = '0;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic [31:0] io_read_data;
    logic [31:0] in_reg0;
    logic [31:0] in_reg1;
    logic        chg_irq;

    io_input_ctrl #(.WIDTH(W), .DEB_CYCLES(D)) dut (
        .io_clk(io_clk), .resetn(resetn), .in_port0(in_port0), .in_port1(in_port1),
        .addr(addr), .rd_en(rd_en), .io_read_data(io_read_data),
        .in_reg0(in_reg0), .in_reg1(in_reg1), .chg_irq(chg_irq)
    );

    always #5 io_clk = ~io_clk;

    int unsigned cyc = 0;
    always @(posedge io_clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        logic [31:0] val;
        int unsigned at;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Pin changed now (at a negedge) -> commit lands 3+D posedges later.
    task automatic expect_commit(input bit port, input logic [31:0] v);
        sb.push_back('{port: port, val: v & MASK, at: cyc + 3 + D});
    endtask

    task automatic wait_change(input bit port, input int max_cyc, output logic [31:0] v, output int unsigned at);
        logic [31:0] prev, cur;
        bit seen = 1'b0;
        prev = port ? in_reg1 : in_reg0;
        v  = prev;
        at = cyc;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge io_clk);
            cur = port ? in_reg1 : in_reg0;
            if (cur !== prev) begin
                seen = 1'b1;
                v    = cur;
                at   = cyc;
            end
        end
    endtask

    task automatic clear_flags();
        @(negedge io_clk);
        addr  = 32'h8;
        rd_en = 1'b1;
        @(negedge io_clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        int unsigned at;
        exp_t e;
        in_port0 = 32'h1F;
        #2 resetn = 1'b0;
        repeat (3) @(negedge io_clk);
        n_checks++; if (in_reg0 !== 32'h0) $display("FAIL reset_in_reg0: got %h expected 00000000", in_reg0); else n_pass++;
        n_checks++; if (chg_irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", chg_irq); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            addr = 32'(i * 4);
            #1;
            n_checks++; if (io_read_data !== 32'h0) $display("FAIL reset_read addr %h: got %h expected 00000000", addr, io_read_data); else n_pass++;
        end
        @(negedge io_clk);
        resetn = 1'b1;
        expect_commit(1'b0, 32'h1F);
        wait_change(1'b0, 30, got, at);
        e = sb.pop_front();
        n_checks++; if (got !== e.val) $display("FAIL reset_commit_val: got %h expected %h", got, e.val); else n_pass++;
        n_checks++; if (at !== e.at) $display("FAIL reset_commit_edge: got cycle %0d expected %0d", at, e.at); else n_pass++;
        addr = 32'h8;
        #1;
        n_checks++; if (io_read_data !== 32'h1) $display("FAIL reset_status: got %h expected 00000001", io_read_data); else n_pass++;
        n_checks++; if (chg_irq !== 1'b1) $display("FAIL reset_commit_irq: got %b expected 1", chg_irq); else n_pass++;
    endtask

    task automatic test_bounce();
        logic [31:0] got;
        int unsigned at;
        exp_t e;
        clear_flags();
        @(negedge io_clk);
        in_port0 = 32'h0;
        expect_commit(1'b0, 32'h0);
        wait_change(1'b0, 30, got, at);
        e = sb.pop_front();
        n_checks++; if (got !== e.val || at !== e.at) $display("FAIL bounce_setup: got %h@%0d expected %h@%0d", got, at, e.val, e.at); else n_pass++;
        clear_flags();
        @(negedge io_clk);
        in_port0 = 32'h3;
        repeat (2) @(negedge io_clk);
        in_port0 = 32'h0;
        repeat (2) @(negedge io_clk);
        in_port0 = 32'h3;
        n_checks++; if (in_reg0 !== 32'h0) $display("FAIL bounce_early_commit: got %h expected 00000000", in_reg0); else n_pass++;
        expect_commit(1'b0, 32'h3);
        wait_change(1'b0, 30, got, at);
        e = sb.pop_front();
        n_checks++; if (got !== e.val) $display("FAIL bounce_val: got %h expected %h", got, e.val); else n_pass++;
        n_checks++; if (at !== e.at) $display("FAIL bounce_edge: got cycle %0d expected %0d", at, e.at); else n_pass++;
        addr = 32'h8;
        #1;
        n_checks++; if (io_read_data !== 32'h1) $display("FAIL bounce_status: got %h expected 00000001", io_read_data); else n_pass++;
    endtask

    task automatic test_bounce_back();
        logic [31:0] got;
        int unsigned at;
        exp_t e;
        bit moved = 1'b0;
        clear_flags();
        @(negedge io_clk);
        in_port1 = 32'h1;
        expect_commit(1'b1, 32'h1);
        wait_change(1'b1, 30, got, at);
        e = sb.pop_front();
        n_checks++; if (got !== e.val || at !== e.at) $display("FAIL bounce_back_setup: got %h@%0d expected %h@%0d", got, at, e.val, e.at); else n_pass++;
        clear_flags();
        @(negedge io_clk);
        in_port1 = 32'h2;
        repeat (3) @(negedge io_clk);
        in_port1 = 32'h1;
        repeat (12) begin
            @(negedge io_clk);
            if (in_reg1 !== 32'h1) moved = 1'b1;
        end
        n_checks++; if (moved) $display("FAIL bounce_back_hold: in_reg1 moved, now %h expected 00000001", in_reg1); else n_pass++;
        addr = 32'h8;
        #1;
        n_checks++; if (io_read_data !== 32'h0) $display("FAIL bounce_back_status: got %h expected 00000000", io_read_data); else n_pass++;
        n_checks++; if (chg_irq !== 1'b0) $display("FAIL bounce_back_irq: got %b expected 0", chg_irq); else n_pass++;
        @(negedge io_clk);
        in_port1 = 32'h2;
        expect_commit(1'b1, 32'h2);
        wait_change(1'b1, 30, got, at);
        e = sb.pop_front();
        n_checks++; if (got !== e.val) $display("FAIL bounce_back_idle_val: got %h expected %h", got, e.val); else n_pass++;
        n_checks++; if (at !== e.at) $display("FAIL bounce_back_idle_edge: got cycle %0d expected %0d", at, e.at); else n_pass++;
    endtask

    task automatic test_clear_on_read();
        logic [31:0] got;
        int unsigned at;
        exp_t e;
        @(negedge io_clk);
        addr  = 32'h8;
        rd_en = 1'b1;
        #1;
        n_checks++; if (io_read_data !== 32'h2) $display("FAIL cor_pre_clear_chg1: got %h expected 00000002", io_read_data); else n_pass++;
        @(negedge io_clk);
        rd_en = 1'b0;
        #1;
        n_checks++; if (io_read_data !== 32'h0) $display("FAIL cor_post_clear_chg1: got %h expected 00000000", io_read_data); else n_pass++;
        in_port0 = 32'hFFFF_FFE5;
        expect_commit(1'b0, 32'hFFFF_FFE5);
        wait_change(1'b0, 30, got, at);
        e = sb.pop_front();
        n_checks++; if (got !== e.val) $display("FAIL width_mask_val: got %h expected %h", got, e.val); else n_pass++;
        n_checks++; if (at !== e.at) $display("FAIL width_mask_edge: got cycle %0d expected %0d", at, e.at); else n_pass++;
        addr  = 32'h8;
        rd_en = 1'b1;
        #1;
        n_checks++; if (io_read_data !== 32'h1) $display("FAIL cor_pre_clear: got %h expected 00000001", io_read_data); else n_pass++;
        n_checks++; if (chg_irq !== 1'b1) $display("FAIL cor_irq_before: got %b expected 1", chg_irq); else n_pass++;
        @(negedge io_clk);
        rd_en = 1'b0;
        #1;
        n_checks++; if (io_read_data !== 32'h0) $display("FAIL cor_post_clear: got %h expected 00000000", io_read_data); else n_pass++;
        n_checks++; if (chg_irq !== 1'b0) $display("FAIL cor_irq_after: got %b expected 0", chg_irq); else n_pass++;
        // Address decode on the committed value.
        addr = 32'h0;   #1;
        n_checks++; if (io_read_data !== 32'h5) $display("FAIL addr_00: got %h expected 00000005", io_read_data); else n_pass++;
        addr = 32'h103; #1;
        n_checks++; if (io_read_data !== 32'h5) $display("FAIL addr_alias_103: got %h expected 00000005", io_read_data); else n_pass++;
        addr = 32'h4;   #1;
        n_checks++; if (io_read_data !== 32'h2) $display("FAIL addr_04: got %h expected 00000002", io_read_data); else n_pass++;
`ifndef IO_INPUT_EDGE_EN
        addr = 32'hC;   #1;
        n_checks++; if (io_read_data !== 32'h0) $display("FAIL addr_0c: got %h expected 00000000", io_read_data); else n_pass++;
`endif
        addr = 32'hFC;  #1;
        n_checks++; if (io_read_data !== 32'h0) $display("FAIL addr_fc: got %h expected 00000000", io_read_data); else n_pass++;
    endtask

    task automatic test_set_over_clear();
        exp_t e;
        @(negedge io_clk);
        in_port0 = 32'hA;
        expect_commit(1'b0, 32'hA);
        repeat (6) @(negedge io_clk);
        addr  = 32'h8;
        rd_en = 1'b1;
        @(negedge io_clk);
        rd_en = 1'b0;
        e = sb.pop_front();
        n_checks++; if (cyc !== e.at) $display("FAIL soc_timing: at cycle %0d expected %0d", cyc, e.at); else n_pass++;
        n_checks++; if (in_reg0 !== e.val) $display("FAIL soc_commit: got %h expected %h", in_reg0, e.val); else n_pass++;
        #1;
        n_checks++; if (io_read_data !== 32'h1) $display("FAIL soc_status: got %h expected 00000001", io_read_data); else n_pass++;
        n_checks++; if (chg_irq !== 1'b1) $display("FAIL soc_irq: got %b expected 1", chg_irq); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] got;
        int unsigned at;
        exp_t e0, e1;
        clear_flags();
        @(negedge io_clk);
        in_port0 = 32'h11;
        in_port1 = 32'h1F;
        expect_commit(1'b0, 32'h11);
        expect_commit(1'b1, 32'h1F);
        wait_change(1'b0, 30, got, at);
        e0 = sb.pop_front();
        e1 = sb.pop_front();
        n_checks++; if (got !== e0.val || at !== e0.at) $display("FAIL simul_port0: got %h@%0d expected %h@%0d", got, at, e0.val, e0.at); else n_pass++;
        n_checks++; if (in_reg1 !== e1.val || cyc !== e1.at) $display("FAIL simul_port1: got %h@%0d expected %h@%0d", in_reg1, cyc, e1.val, e1.at); else n_pass++;
        addr = 32'h8;
        #1;
        n_checks++; if (io_read_data !== 32'h3) $display("FAIL simul_status: got %h expected 00000003", io_read_data); else n_pass++;
    endtask

    task automatic test_rise();
        logic [31:0] got;
        int unsigned at;
        exp_t e;
        logic [31:0] seq [3];
        seq[0] = 32'h0;
        seq[1] = 32'h12;
        seq[2] = 32'h0;
        for (int s = 0; s < 3; s++) begin
            clear_flags();
            if (s == 1) begin
                @(negedge io_clk);
                addr  = 32'hC;
                rd_en = 1'b1;
                @(negedge io_clk);
                addr  = 32'h10;
                @(negedge io_clk);
                rd_en = 1'b0;
            end
            @(negedge io_clk);
            in_port1 = seq[s];
            expect_commit(1'b1, seq[s]);
            wait_change(1'b1, 30, got, at);
            e = sb.pop_front();
            n_checks++; if (got !== e.val || at !== e.at) $display("FAIL rise_commit_%0d: got %h@%0d expected %h@%0d", s, got, at, e.val, e.at); else n_pass++;
        end
        // Last commit was 12->0: no rise; earlier 0->12 rise was not yet cleared.
        addr  = 32'h10;
        rd_en = 1'b1;
        #1;
        n_checks++; if (io_read_data !== RISE_EXP) $display("FAIL rise1_read: got %h expected %h", io_read_data, RISE_EXP); else n_pass++;
        @(negedge io_clk);
        rd_en = 1'b0;
        #1;
        n_checks++; if (io_read_data !== 32'h0) $display("FAIL rise1_after_clear: got %h expected 00000000", io_read_data); else n_pass++;
        clear_flags();
        #1;
        n_checks++; if (chg_irq !== 1'b0) $display("FAIL rise_irq_clear: got %b expected 0", chg_irq); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_bounce_back();
        test_clear_on_read();
        test_set_over_clear();
        test_simultaneous();
        test_rise();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/io_input_ctrl.md
Name: io_input_ctrl

Overview:
- Sequencing controller for the CPU's memory-mapped input ports (switches/buttons): synchronises, debounces and commits port samples into the input registers, instead of a blind every-cycle copy.
- Keeps a clear-on-read change-status register and a change interrupt line, so software can poll or react.
- Sits between board pins and the data-memory read mux; its read port feeds the CPU load path.

Parameters:
- WIDTH, 5, number of live low bits per input port (1..32); bits [31:WIDTH] of committed registers are always 0.
- DEB_CYCLES, 4, consecutive stable cycles required before commit (>=1); counter width = clog2(DEB_CYCLES)+1.

Ports:
- io_clk  input  1  I/O clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_port0  input  32  raw pin input, port 0; only [WIDTH-1:0] used.
- in_port1  input  32  raw pin input, port 1; only [WIDTH-1:0] used.
- addr  input  32  CPU byte address; word index addr[7:2] decoded.
- rd_en  input  1  CPU load strobe for the I/O space, sampled on io_clk.
- io_read_data  output  32  combinational read data for addr.
- in_reg0  output  32  committed, debounced port 0 value.
- in_reg1  output  32  committed, debounced port 1 value.
- chg_irq  output  1  high while any change flag is set.

Behaviour:
- Reset (async, resetn=0): in_reg0/1=0, sync flops=0, both FSMs IDLE, counters=0, change flags=0, chg_irq=0. Reset mid-debounce abandons the candidate; no commit.
- Per-port 2-flop synchroniser on [WIDTH-1:0]; FSM compares sync2 output (s) against committed value (c).
- FSM states per port (independent, identical):
  - IDLE: s==c stays. s!=c: cand<=s, cnt<=0, go COUNT.
  - COUNT, priority order: s==c (bounced back) -> IDLE, no commit. s!=cand -> cand<=s, cnt<=0, stay. cnt==DEB_CYCLES-1 -> c<=cand, set chg flag, go IDLE. Else cnt<=cnt+1.
- Latency: pin stable from before edge k -> committed at edge k+2+DEB_CYCLES (k+6 for default).
- Address map (addr[7:2]):
  - 0: in_reg0
  - 1: in_reg1
  - 2: status {30'b0, chg1, chg0}
  - other: 0
- io_read_data is purely combinational; a read has no side effect unless rd_en=1.
- Clear-on-read: rd_en=1 and addr[7:2]==2 at an edge clears both chg flags. io_read_data shows the pre-clear value in that cycle.
- Set-over-clear: a commit on the same edge as a clearing read leaves that flag set.
- chg_irq = chg0 | chg1, driven from registers, glitch-free.
- Ports are fully independent; simultaneous commits on both set both flags on the same edge.

Optional Feature:
- Macro IO_INPUT_EDGE_EN.
- Defined:
  - Adds per-port rise registers rise0/rise1 [WIDTH-1:0]. Bit i is set at commit when c[i] goes 0->1.
  - Readable at addr[7:2]=3 (rise0) and 4 (rise1), zero-extended.
  - Clear-on-read per register with rd_en; set-over-clear applies.
  - chg_irq additionally ORs any nonzero rise bit.
- Not defined: no rise registers; indices 3 and 4 read 0; chg_irq as above.

Test Plan:
- Reset: hold resetn=0 with in_port0=5'h1F -> in_reg0=0, io_read_data=0 at all addresses, chg_irq=0. Release at edge 0, pins stable -> in_reg0=32'h1F at edge 6, chg0=1, chg_irq=1.
- Bounce: port0 toggles 0->3->0->3 every 2 cycles, then holds 3 -> no commit during toggling; in_reg0=3 exactly 6 edges after the last toggle; exactly one chg0 set.
- Bounce-back: port1 1->2 for 3 cycles then back to 1 -> in_reg1 stays 1, chg1 stays 0, FSM returns to IDLE.
- Clear-on-read: chg0=1, rd_en=1, addr=32'h08 -> io_read_data=32'h1 that cycle, then 0; chg_irq drops. Repeat with port0 commit on the same edge -> chg0 remains 1.
- Width masking: in_port0=32'hFFFF_FFE5 -> in_reg0 commits 32'h5; addr=32'h0C reads 0 without the macro.
- IO_INPUT_EDGE_EN: port1 commits 0->5'h12 -> addr=32'h10 reads 32'h12. After a clearing read it reads 0. A 5'h12->0 commit leaves rise1 at 0.
